dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer that shares the single-port data memory between the CPU load/store stage (port 0) and a loader/debug engine (port 1). It latches one request at a time, drives the memory's address, write-data and write-enable for exactly one cycle, and captures read data. It returns a one-cycle acknowledge to the requester. Arbitration is round-robin, so neither port can starve the other.

Parameters:
ADDRESS_WIDTH, 16, memory address width; must match the data memory instance.
DATA_WIDTH, 32, data word width.

Ports:
Clk  input  1  clock; all state changes on posedge.
Reset  input  1  synchronous, active-high reset.
Req0  input  1  port 0 request; held high until Ack0.
Write0  input  1  port 0: 1 = write, 0 = read; held with Req0.
Addr0  input  ADDRESS_WIDTH  port 0 address.
WData0  input  DATA_WIDTH  port 0 write data.
Ack0  output  1  port 0 one-cycle completion pulse.
Req1, Write1, Addr1, WData1, Ack1  same as port 0, for port 1.
RData  output  DATA_WIDTH  read data; valid in the Ack cycle, held until the next read completes.
MemAddress  output  ADDRESS_WIDTH  to data memory Address.
MemWriteData  output  DATA_WIDTH  to data memory WriteData.
MemWrite  output  1  to data memory MemWrite.
MemData  input  DATA_WIDTH  from data memory (combinational read).

Behaviour:
- Reset (sync, high): state=IDLE; Ack0=Ack1=0; RData=0; MemWrite=0; MemAddress=0; MemWriteData=0; last-grant pointer=1, so port 0 wins the first tie.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Neither Req high: stay in IDLE.
  - One Req high: grant that port.
  - Both Req high: grant the port not equal to the last-grant pointer.
  - On grant, register the port's Write, Addr and WData into a latch, record the grant, update the pointer, and go to ACCESS.
- ACCESS (one cycle):
  - MemAddress and MemWriteData come from the latched request.
  - MemWrite = latched Write AND NOT Reset.
  - On read, RData <= MemData at the end of the cycle. On write, RData is unchanged.
  - Next state is RESP.
- RESP (one cycle): Ack of the granted port = 1, the other Ack = 0. Next state is IDLE.
- Requester changes to Req, Write, Addr and WData while the request is pending are ignored, because the fields were latched at grant.
- Requester must drop Req in the cycle after Ack. A Req still high in IDLE is treated as a new request.
- Latency: Req sampled high in IDLE at edge N, ACCESS is cycle N+1, Ack and RData valid in cycle N+2. Peak throughput is one access per 3 cycles.
- Outside ACCESS: MemWrite=0. MemAddress and MemWriteData hold their last values (registered), so there is no glitching on the memory bus.
- Ack0 and Ack1 are never high together and never high outside RESP.
- Reset in any state:
  - Next state is IDLE, with no Ack for the aborted request.
  - Reset asserted during the ACCESS cycle suppresses the write (MemWrite gated).
  - The requester must re-issue after reset.
- Address and data pass through at full width with no arithmetic. Address wrap is the memory's concern.

Optional Feature:
DMEM_ARB_PERF_EN.
- Defined: adds outputs GrantCount0, GrantCount1 and ConflictCount, each 32 bits.
  - GrantCount0/GrantCount1 increment on each grant to that port.
  - ConflictCount increments each IDLE cycle where both Req are high and a grant is made.
  - All three clear on Reset and wrap modulo 2^32.
- Undefined: no counters and no extra ports; arbitration timing is identical.

Test Plan:
- Port 0 write Addr0=0x0010, WData0=0xDEADBEEF; then port 0 read 0x0010 -> MemWrite high exactly in one ACCESS cycle; Ack0 2 cycles after Req; RData=0xDEADBEEF with the second Ack0; Ack1 never high.
- Req0 and Req1 asserted in the same cycle, both reads, held until acked, repeated 4 times -> grants alternate 0,1,0,1 starting with port 0; no Ack overlap.
- Port 1 write 0x00FF=0x12345678 while Req0 is held high continuously -> port 0 is served at most once between consecutive port 1 grants; port 1 Ack1 arrives within 6 cycles.
- Assert Reset during ACCESS of a port 1 write to 0x0020 (value 0xAAAA5555) -> MemWrite=0 that cycle; no Ack1; a later port 0 read of 0x0020 returns the pre-test contents (bench-preloaded 0x0); state is IDLE the cycle after reset.
- Change Addr0 from 0x0004 to 0x0008 during ACCESS of a read -> MemAddress=0x0004; RData is the contents at 0x0004.
- DMEM_ARB_PERF_EN defined: 3 simultaneous-request rounds plus 2 solo port 0 requests -> GrantCount0=5, GrantCount1=3, ConflictCount=3; after Reset all are 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing the single-port data memory between the CPU (port 0) and loader (port 1).
// Define DMEM_ARB_PERF_EN to add grant and conflict counters.
module dmem_arbiter #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Req0,
    input  logic                     Write0,
    input  logic [ADDRESS_WIDTH-1:0] Addr0,
    input  logic [DATA_WIDTH-1:0]    WData0,
    output logic                     Ack0,
    input  logic                     Req1,
    input  logic                     Write1,
    input  logic [ADDRESS_WIDTH-1:0] Addr1,
    input  logic [DATA_WIDTH-1:0]    WData1,
    output logic                     Ack1,
    output logic [DATA_WIDTH-1:0]    RData,
    output logic [ADDRESS_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0]    MemWriteData,
    output logic                     MemWrite,
    input  logic [DATA_WIDTH-1:0]    MemData
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]              GrantCount0,
    output logic [31:0]              GrantCount1,
    output logic [31:0]              ConflictCount
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    state_t next_state;
    logic   grant_valid;
    logic   grant_port;
    logic   last_grant;
    logic   cur_port;
    logic   lat_write;

    always_comb begin
        next_state  = state;
        grant_valid = 1'b0;
        grant_port  = 1'b0;
        case (state)
            IDLE: begin
                if (Req0 && Req1) begin
                    grant_valid = 1'b1;
                    grant_port  = ~last_grant;
                end else if (Req0) begin
                    grant_valid = 1'b1;
                    grant_port  = 1'b0;
                end else if (Req1) begin
                    grant_valid = 1'b1;
                    grant_port  = 1'b1;
                end
                if (grant_valid) begin
                    next_state = ACCESS;
                end
            end
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // MemAddress/MemWriteData double as the request latch, so the bus only moves at grant time.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            cur_port     <= 1'b0;
            lat_write    <= 1'b0;
            MemAddress   <= '0;
            MemWriteData <= '0;
            RData        <= '0;
            Ack0         <= 1'b0;
            Ack1         <= 1'b0;
        end else begin
            state <= next_state;
            Ack0  <= (state == ACCESS) && !cur_port;
            Ack1  <= (state == ACCESS) && cur_port;
            if (grant_valid) begin
                cur_port     <= grant_port;
                last_grant   <= grant_port;
                lat_write    <= grant_port ? Write1 : Write0;
                MemAddress   <= grant_port ? Addr1 : Addr0;
                MemWriteData <= grant_port ? WData1 : WData0;
            end
            if ((state == ACCESS) && !lat_write) begin
                RData <= MemData;
            end
        end
    end

    // Gated by Reset so an aborted write never reaches the memory.
    assign MemWrite = (state == ACCESS) && lat_write && !Reset;

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            GrantCount0   <= '0;
            GrantCount1   <= '0;
            ConflictCount <= '0;
        end else if (grant_valid) begin
            if (grant_port) begin
                GrantCount1 <= GrantCount1 + 32'd1;
            end else begin
                GrantCount0 <= GrantCount0 + 32'd1;
            end
            if (Req0 && Req1) begin
                ConflictCount <= ConflictCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: bench-side memory, expected-response queue, round-robin model.
module tb_dmem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          Clk;
    logic          Reset;
    logic          Req0, Write0, Ack0;
    logic [AW-1:0] Addr0;
    logic [DW-1:0] WData0;
    logic          Req1, Write1, Ack1;
    logic [AW-1:0] Addr1;
    logic [DW-1:0] WData1;
    logic [DW-1:0] RData;
    logic [AW-1:0] MemAddress;
    logic [DW-1:0] MemWriteData;
    logic          MemWrite;
    logic [DW-1:0] MemData;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]   GrantCount0, GrantCount1, ConflictCount;
`endif

    dmem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Req0         (Req0),
        .Write0       (Write0),
        .Addr0        (Addr0),
        .WData0       (WData0),
        .Ack0         (Ack0),
        .Req1         (Req1),
        .Write1       (Write1),
        .Addr1        (Addr1),
        .WData1       (WData1),
        .Ack1         (Ack1),
        .RData        (RData),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemWrite     (MemWrite),
        .MemData      (MemData)
`ifdef DMEM_ARB_PERF_EN
        ,
        .GrantCount0  (GrantCount0),
        .GrantCount1  (GrantCount1),
        .ConflictCount(ConflictCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Bench memory (combinational read) plus a preload path used while the DUT is in reset.
    bit [31:0]  mem [0:4095];
    bit [31:0]  exp_mem [0:4095];
    logic       pre_en;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;

    assign MemData = mem[MemAddress[11:0]];

    always @(posedge Clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (MemWrite) begin
            mem[MemAddress[11:0]] <= MemWriteData;
        end
    end

    typedef struct {
        logic        port;
        logic        write;
        logic [31:0] data;
    } sb_t;

    sb_t  sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mw_count = 0;
    logic ptr_model;
    int   gcount0, gcount1, conflicts;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Expected read data comes from the bench's own model of memory contents, in service order.
    function automatic void pushExpected(input logic port, input logic write,
                                         input logic [15:0] addr, input logic [31:0] wdata);
        sb_t e;
        e.port  = port;
        e.write = write;
        e.data  = write ? wdata : exp_mem[addr[11:0]];
        if (write) exp_mem[addr[11:0]] = wdata;
        sb_q.push_back(e);
        ptr_model = port;
        if (port) gcount1++;
        else gcount0++;
    endfunction

    function automatic void resetModel();
        ptr_model = 1'b1;
        gcount0   = 0;
        gcount1   = 0;
        conflicts = 0;
        sb_q.delete();
    endfunction

    always @(negedge Clk) begin
        if (MemWrite) mw_count++;
        if (Ack0 || Ack1) begin
            sb_t e;
            checkOutput("ack_onehot", {31'd0, Ack0 & Ack1}, 32'd0);
            if (sb_q.size() == 0) begin
                checkOutput("sb_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("ack_port", {31'd0, Ack1}, {31'd0, e.port});
                if (!e.write) checkOutput("rdata", RData, e.data);
            end
        end
    end

    task automatic preload(input logic [11:0] addr, input logic [31:0] data);
        @(negedge Clk);
        pre_en   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        exp_mem[addr] = data;
        @(negedge Clk);
        pre_en = 1'b0;
    endtask

    // Single request from one port; inputs are scrambled during ACCESS to prove the grant-time latch.
    task automatic applyStimulus(input logic port, input logic write,
                                 input logic [15:0] addr, input logic [31:0] wdata);
        int   cycles;
        bit   done;
        logic ack;
        done = 0;
        @(negedge Clk);
        if (port) begin
            Req1 = 1'b1; Write1 = write; Addr1 = addr; WData1 = wdata;
        end else begin
            Req0 = 1'b1; Write0 = write; Addr0 = addr; WData0 = wdata;
        end
        pushExpected(port, write, addr, wdata);
        cycles = 0;
        while (!done && cycles < 10) begin
            @(negedge Clk);
            cycles++;
            ack = port ? Ack1 : Ack0;
            if (cycles == 1) begin
                checkOutput("acc_addr", {16'd0, MemAddress}, {16'd0, addr});
                checkOutput("acc_we", {31'd0, MemWrite}, {31'd0, write});
                if (write) checkOutput("acc_wdata", MemWriteData, wdata);
                if (port) begin
                    Addr1 = addr ^ 16'h000C; WData1 = ~wdata; Write1 = ~write;
                end else begin
                    Addr0 = addr ^ 16'h000C; WData0 = ~wdata; Write0 = ~write;
                end
            end
            if (ack) begin
                checkOutput("latency", cycles, 32'd2);
                done = 1;
            end
        end
        if (!done) checkOutput("ack_timeout", 32'd0, 32'd1);
        Req0 = 1'b0;
        Req1 = 1'b0;
    endtask

    task automatic doBothReads(input logic [15:0] a0, input logic [15:0] a1);
        int   cycles;
        bit   d0, d1;
        logic first;
        d0 = 0;
        d1 = 0;
        @(negedge Clk);
        Req0 = 1'b1; Write0 = 1'b0; Addr0 = a0;
        Req1 = 1'b1; Write1 = 1'b0; Addr1 = a1;
        first = ~ptr_model;
        conflicts++;
        if (first == 1'b0) begin
            pushExpected(1'b0, 1'b0, a0, 32'd0);
            pushExpected(1'b1, 1'b0, a1, 32'd0);
        end else begin
            pushExpected(1'b1, 1'b0, a1, 32'd0);
            pushExpected(1'b0, 1'b0, a0, 32'd0);
        end
        cycles = 0;
        while (!(d0 && d1) && cycles < 20) begin
            @(negedge Clk);
            cycles++;
            if (Ack0) begin Req0 = 1'b0; d0 = 1; end
            if (Ack1) begin Req1 = 1'b0; d1 = 1; end
        end
        if (!(d0 && d1)) checkOutput("both_timeout", 32'd0, 32'd1);
        Req0 = 1'b0;
        Req1 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   mw0, cycles, p0_acks;
        bit   done;
        logic first;
        logic p;
        logic [15:0] a;
        logic [31:0] d;

        Reset = 1'b1;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        Req0 = 0; Write0 = 0; Addr0 = '0; WData0 = '0;
        Req1 = 0; Write1 = 0; Addr1 = '0; WData1 = '0;
        resetModel();

        preload(12'h004, 32'hCAFE_0004);
        preload(12'h008, 32'h0BAD_0008);
        for (int i = 0; i < 8; i++) preload(12'h100 + 12'(i), 32'h5000_0000 + 32'(i * 17));

        @(negedge Clk);
        checkOutput("rst_ack0", {31'd0, Ack0}, 32'd0);
        checkOutput("rst_ack1", {31'd0, Ack1}, 32'd0);
        checkOutput("rst_memwrite", {31'd0, MemWrite}, 32'd0);
        checkOutput("rst_rdata", RData, 32'd0);
        checkOutput("rst_memaddr", {16'd0, MemAddress}, 32'd0);
        checkOutput("rst_memwdata", MemWriteData, 32'd0);
        Reset = 1'b0;
        resetModel();

        $display("[TB] write then read back on port 0");
        mw0 = mw_count;
        applyStimulus(1'b0, 1'b1, 16'h0010, 32'hDEAD_BEEF);
        checkOutput("mw_pulses_write", mw_count - mw0, 32'd1);
        mw0 = mw_count;
        applyStimulus(1'b0, 1'b0, 16'h0010, 32'd0);
        checkOutput("mw_pulses_read", mw_count - mw0, 32'd0);

        $display("[TB] simultaneous requests, four rounds");
        for (int r = 0; r < 4; r++) doBothReads(16'h0100 + 16'(2 * r), 16'h0101 + 16'(2 * r));

        $display("[TB] port 1 write while port 0 holds its request");
        @(negedge Clk);
        Req0 = 1'b1; Write0 = 1'b0; Addr0 = 16'h0102;
        Req1 = 1'b1; Write1 = 1'b1; Addr1 = 16'h00FF; WData1 = 32'h1234_5678;
        first = ~ptr_model;
        if (first == 1'b0) pushExpected(1'b0, 1'b0, 16'h0102, 32'd0);
        pushExpected(1'b1, 1'b1, 16'h00FF, 32'h1234_5678);
        cycles = 0;
        p0_acks = 0;
        done = 0;
        while (!done && cycles < 12) begin
            @(negedge Clk);
            cycles++;
            if (Ack0) p0_acks++;
            if (Ack1) begin
                checkOutput("ack1_within_6", {31'd0, cycles <= 6}, 32'd1);
                done = 1;
            end
        end
        if (!done) checkOutput("ack1_timeout", 32'd0, 32'd1);
        Req0 = 1'b0;
        Req1 = 1'b0;
        checkOutput("p0_between", p0_acks, (first == 1'b0) ? 32'd1 : 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h00FF, 32'd0);

        $display("[TB] reset during a port 1 write access");
        @(negedge Clk);
        Req1 = 1'b1; Write1 = 1'b1; Addr1 = 16'h0020; WData1 = 32'hAAAA_5555;
        @(negedge Clk);
        checkOutput("abort_acc_addr", {16'd0, MemAddress}, 32'h0000_0020);
        Reset = 1'b1;
        #1;
        checkOutput("abort_memwrite", {31'd0, MemWrite}, 32'd0);
        Req1 = 1'b0;
        @(negedge Clk);
        checkOutput("abort_no_ack1", {31'd0, Ack1}, 32'd0);
        checkOutput("abort_no_ack0", {31'd0, Ack0}, 32'd0);
        checkOutput("abort_memaddr", {16'd0, MemAddress}, 32'd0);
        checkOutput("abort_rdata", RData, 32'd0);
        Reset = 1'b0;
        resetModel();
        applyStimulus(1'b0, 1'b0, 16'h0020, 32'd0);

        $display("[TB] address change during access");
        applyStimulus(1'b0, 1'b0, 16'h0004, 32'd0);

        $display("[TB] random write/read-back pairs");
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom_range(0, 4095));
            d = $urandom;
            p = 1'($urandom_range(0, 1));
            applyStimulus(p, 1'b1, a, d);
            applyStimulus(~p, 1'b0, a, 32'd0);
        end

`ifdef DMEM_ARB_PERF_EN
        $display("[TB] performance counters");
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        resetModel();
        checkOutput("perf_g0_rst", GrantCount0, 32'd0);
        checkOutput("perf_g1_rst", GrantCount1, 32'd0);
        checkOutput("perf_cf_rst", ConflictCount, 32'd0);
        for (int r = 0; r < 3; r++) doBothReads(16'h0100 + 16'(r), 16'h0104 + 16'(r));
        applyStimulus(1'b0, 1'b0, 16'h0004, 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0008, 32'd0);
        @(negedge Clk);
        checkOutput("perf_g0", GrantCount0, 32'(gcount0));
        checkOutput("perf_g1", GrantCount1, 32'(gcount1));
        checkOutput("perf_cf", ConflictCount, 32'(conflicts));
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        resetModel();
        checkOutput("perf_g0_clr", GrantCount0, 32'd0);
        checkOutput("perf_g1_clr", GrantCount1, 32'd0);
        checkOutput("perf_cf_clr", ConflictCount, 32'd0);
`endif

        repeat (3) @(negedge Clk);
        checkOutput("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
